alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised execute unit: integer ALU plus iterative multiply/divide behind valid/ready handshakes. Sits between the decode/issue stage and writeback of the Scheme VM core. Single-cycle ops keep full throughput when the response is drained immediately. MUL/DIV ops occupy the unit for a fixed multi-cycle latency, and only one operation is in flight at a time.

## Interface
- XLEN, default 32: operand and result width; must be a power of two, at least 8.
- SHW, default $clog2(XLEN): shift-amount width (derived; do not override).
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit accepts a request this cycle.
- req_op  in  5  operation code (package constants).
- req_lhs  in  XLEN  first operand.
- req_rhs  in  XLEN  second operand.
- kill  in  1  synchronous abort of the in-flight operation.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  XLEN  result.
- resp_err  out  1  op code was illegal.

## Operation
- Op codes 0-15: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, EQ, NEQ, LT, GE, LTU, GEU.
- Op codes 16-23: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Op codes 24-31 are illegal.
- Comparison ops return a zero-extended 1-bit result.
- Shifts use only rhs[SHW-1:0]; SRA is arithmetic on the signed lhs.
- ADD, SUB and MUL wrap modulo 2^XLEN.
- MULH* return the upper XLEN bits of the 2·XLEN product; MULHSU treats lhs as signed and rhs as unsigned.
- Division by zero: quotient is all ones; remainder is lhs.
- Signed overflow (lhs = most-negative, rhs = -1): quotient is lhs; remainder is 0.
- Both special division cases complete on the single-cycle path.
- Illegal op: resp_data 0, resp_err 1, single-cycle path.
- States:
  - IDLE: req_ready 1.
  - MUL: iterating.
  - DIV: iterating.
  - DONE: resp_valid 1.
- Transitions:
  - IDLE, on accept: go to DONE for single-cycle ops; go to MUL or DIV otherwise.
  - MUL/DIV: go to DONE when the step counter reaches XLEN-1.
  - DONE with resp_ready 1: go to IDLE, or directly to the next op's state if a new request is accepted the same cycle.
- req_ready = (state==IDLE) | (state==DONE & resp_ready). This is a combinational path from resp_ready.
- kill:
  - Forces IDLE next cycle from any state and discards the result.
  - resp_valid drops next cycle.
  - A request offered in the same cycle as kill is not accepted; req_ready is 0 while kill is 1.
- resp_data and resp_err hold stable while resp_valid=1 and resp_ready=0.
- Operands are captured on accept; later changes on the req_* inputs have no effect.

## Timing
- Reset values:
  - state IDLE
  - req_ready 1
  - resp_valid 0
  - resp_data 0
  - resp_err 0
  - step counter 0
- Asserting reset_n mid-operation aborts immediately and asynchronously.
- Single-cycle ops: accepted in cycle N; resp_valid=1 in cycle N+1.
- MUL* and DIV/REM (non-special cases): accepted in cycle N; resp_valid=1 in cycle N+XLEN+1.
- Back-to-back single-cycle ops with resp_ready held high: one result per cycle.
- Multiplier: radix-2 shift-add over magnitudes, sign fix-up on the last step.
- Divider: restoring, one quotient bit per cycle, sign fix-up on the last step.

## Configuration
- ALU_MDU_DIV_EN defined:
  - DIV, DIVU, REM and REMU are implemented as described above.
- ALU_MDU_DIV_EN undefined:
  - The divider is not instantiated.
  - Op codes 20-23 are treated as illegal: resp_data 0, resp_err 1, single-cycle latency.
  - MUL* is unaffected.

## Structure
- Shared package alu_mdu_pkg holds:
  - op-code localparams (the 5-bit encoding above);
  - state encoding;
  - helper predicates is_mul(op), is_div(op) and is_legal(op).
- The single-cycle ALU datapath stays inline in alu_mdu.
- Sub-module alu_div_iter: the iterative restoring divider.
  - Ports: start, signed_mode, want_rem, operands, done, result.
  - Instantiated only under ALU_MDU_DIV_EN.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 1 with resp_ready=1 -> resp_valid one cycle after accept; data 0x80000000; err 0.
- Stream SLL 1<<33, SRA 0x80000000>>>4, SLT -1<1 back-to-back with resp_ready=1 -> 0x2, 0xF8000000, 0x1 on consecutive cycles.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000 after XLEN+1 cycles. MULHU of the same operands -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 5/0 -> 0xFFFFFFFF in 1 cycle. DIV 0x80000000/-1 -> 0x80000000 in 1 cycle.
- Start DIV, assert kill at step 10 -> resp_valid never rises; next ADD 2+3 returns 5 normally. Repeat with reset_n low mid-op -> all outputs return to reset values.
- Op 25 -> resp_err 1, data 0. With ALU_MDU_DIV_EN undefined, op 20 -> resp_err 1. Hold resp_ready=0 for 5 cycles -> resp_data stable and req_ready 0.

Source files
------------

// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: op codes, FSM states and op-class predicates for alu_mdu (divider ops legal only with ALU_MDU_DIV_EN)
package alu_mdu_pkg;
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7;
  localparam logic [4:0] OP_OR = 5'd8, OP_AND = 5'd9, OP_EQ = 5'd10, OP_NEQ = 5'd11;
  localparam logic [4:0] OP_LT = 5'd12, OP_GE = 5'd13, OP_LTU = 5'd14, OP_GEU = 5'd15;
  localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
  localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22, OP_REMU = 5'd23;
`ifdef ALU_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  function automatic logic is_mul(input logic [4:0] op);
    return op[4:2] == 3'b100;
  endfunction
  function automatic logic is_div(input logic [4:0] op);
    return op[4:2] == 3'b101;
  endfunction
  function automatic logic is_legal(input logic [4:0] op);
    return op[4:3] != 2'b11 && (DIV_EN || !is_div(op));
  endfunction
endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: restoring divider, one quotient bit per cycle, sign fix-up folded into the last-step result
module alu_div_iter
  import alu_mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            signed_mode,
  input  logic            want_rem,
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  output logic            done,
  output logic [XLEN-1:0] result
);
  logic busy, qneg, rneg, wrem, lneg, rhneg;
  logic [SHW-1:0] cnt;
  logic [XLEN-1:0] rem, quo, dvs, rem_n, quo_n;
  logic [XLEN:0] sh, diff;
  assign lneg = signed_mode & lhs[XLEN-1];
  assign rhneg = signed_mode & rhs[XLEN-1];
  assign sh = {rem, quo[XLEN-1]};
  assign diff = sh - {1'b0, dvs};
  assign rem_n = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_n = {quo[XLEN-2:0], ~diff[XLEN]};
  assign done = busy && cnt == SHW'(XLEN - 1);
  // result is only meaningful while done is high; the caller captures it then
  assign result = wrem ? (rneg ? -rem_n : rem_n) : (qneg ? -quo_n : quo_n);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      busy <= 1'b0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      wrem <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      rem <= '0;
      quo <= lneg ? -lhs : lhs;
      dvs <= rhneg ? -rhs : rhs;
      qneg <= lneg ^ rhneg;
      rneg <= lneg;
      wrem <= want_rem;
    end else if (busy) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt + 1'b1;
      busy <= ~done;
    end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus iterative MUL/DIV behind valid/ready; divider present only with ALU_MDU_DIV_EN
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_op,
  input  logic [XLEN-1:0] req_lhs,
  input  logic [XLEN-1:0] req_rhs,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err
);
  state_t state, state_n;
  logic [SHW-1:0] cnt, sh;
  logic [2*XLEN-1:0] mp, mp_n, prod;
  logic [XLEN:0] msum;
  logic [XLEN-1:0] ma, alu, res, div_res;
  logic mneg, mhi, err, acc, legal, dz, ovf, special, multi, div_done, sa, sb, mlast;
  assign sh = req_rhs[SHW-1:0];
  assign legal = is_legal(req_op);
  assign dz = req_rhs == '0;
  assign ovf = (req_op == OP_DIV || req_op == OP_REM) && req_lhs == {1'b1, {(XLEN-1){1'b0}}} && &req_rhs;
  assign special = is_div(req_op) & (dz | ovf);
  assign multi = legal & (is_mul(req_op) | (is_div(req_op) & ~special));
  assign req_ready = ~kill & (state == S_IDLE || (state == S_DONE && resp_ready));
  assign acc = req_valid & req_ready;
  assign resp_valid = state == S_DONE;
  assign resp_data = res;
  assign resp_err = err;
  assign sa = req_op != OP_MULHU;
  assign sb = req_op == OP_MUL || req_op == OP_MULH;
  assign msum = {1'b0, mp[2*XLEN-1:XLEN]} + {1'b0, ma & {XLEN{mp[0]}}};
  assign mp_n = {msum, mp[XLEN-1:1]};
  assign prod = mneg ? -mp_n : mp_n;
  assign mlast = cnt == SHW'(XLEN - 1);
  always_comb begin
    alu = '0;
    case (req_op)
      OP_ADD:  alu = req_lhs + req_rhs;
      OP_SUB:  alu = req_lhs - req_rhs;
      OP_SLL:  alu = req_lhs << sh;
      OP_SLT:  alu = XLEN'($signed(req_lhs) < $signed(req_rhs));
      OP_SLTU: alu = XLEN'(req_lhs < req_rhs);
      OP_XOR:  alu = req_lhs ^ req_rhs;
      OP_SRL:  alu = req_lhs >> sh;
      OP_SRA:  alu = $signed(req_lhs) >>> sh;
      OP_OR:   alu = req_lhs | req_rhs;
      OP_AND:  alu = req_lhs & req_rhs;
      OP_EQ:   alu = XLEN'(req_lhs == req_rhs);
      OP_NEQ:  alu = XLEN'(req_lhs != req_rhs);
      OP_LT:   alu = XLEN'($signed(req_lhs) < $signed(req_rhs));
      OP_GE:   alu = XLEN'($signed(req_lhs) >= $signed(req_rhs));
      OP_LTU:  alu = XLEN'(req_lhs < req_rhs);
      OP_GEU:  alu = XLEN'(req_lhs >= req_rhs);
      OP_DIV, OP_DIVU: alu = dz ? '1 : req_lhs;
      OP_REM, OP_REMU: alu = dz ? req_lhs : '0;
      default: alu = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    if (kill) state_n = S_IDLE;
    else if (acc) state_n = multi ? (is_mul(req_op) ? S_MUL : S_DIV) : S_DONE;
    else if (state == S_MUL && mlast) state_n = S_DONE;
    else if (state == S_DIV && div_done) state_n = S_DONE;
    else if (state == S_DONE && resp_ready) state_n = S_IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      cnt <= '0;
      res <= '0;
      err <= 1'b0;
      mp <= '0;
      ma <= '0;
      mneg <= 1'b0;
      mhi <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (acc || kill) ? '0 : (state == S_MUL || state == S_DIV) ? cnt + 1'b1 : cnt;
      if (acc) begin
        if (!multi) res <= legal ? alu : '0;
        err <= ~legal;
        ma <= (sa & req_lhs[XLEN-1]) ? -req_lhs : req_lhs;
        mp <= {{XLEN{1'b0}}, (sb & req_rhs[XLEN-1]) ? -req_rhs : req_rhs};
        mneg <= (sa & req_lhs[XLEN-1]) ^ (sb & req_rhs[XLEN-1]);
        mhi <= req_op != OP_MUL;
      end else if (state == S_MUL) begin
        mp <= mp_n;
        if (mlast) res <= mhi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
      end else if (state == S_DIV && div_done) begin
        res <= div_res;
      end
    end
`ifdef ALU_MDU_DIV_EN
  alu_div_iter #(.XLEN(XLEN), .SHW(SHW)) u_div (
    .clk(clk),
    .reset_n(reset_n),
    .start(acc & multi & is_div(req_op)),
    .signed_mode(~req_op[0]),
    .want_rem(req_op[1]),
    .lhs(req_lhs),
    .rhs(req_rhs),
    .done(div_done),
    .result(div_res)
  );
`else
  assign div_done = 1'b0;
  assign div_res = '0;
`endif
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu with XLEN=32
module tb_alu_mdu;
  import alu_mdu_pkg::*;
  logic clk = 1'b0, reset_n = 1'b1, req_valid = 1'b0, kill = 1'b0, resp_ready = 1'b0;
  logic req_ready, resp_valid, resp_err;
  logic [4:0] req_op = '0;
  logic [31:0] req_lhs = '0, req_rhs = '0, resp_data;
  int checks = 0, errors = 0, lat = 0, seen = 0;
  always #5 clk = ~clk;
  alu_mdu #(.XLEN(32)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_lhs(req_lhs),
    .req_rhs(req_rhs),
    .kill(kill),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_err(resp_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [4:0] op, input logic [31:0] l, input logic [31:0] r);
    req_op = op;
    req_lhs = l;
    req_rhs = r;
    req_valid = 1'b1;
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask
  initial begin
    #2 reset_n = 1'b0;
    repeat (2) tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    reset_n = 1'b1;
    tick();
    run(OP_ADD, 32'h7FFF_FFFF, 32'd1);
    chk("add_lat", lat, 32'd1);
    chk("add_data", resp_data, 32'h8000_0000);
    chk("add_err", 32'(resp_err), 32'd0);
    req_valid = 1'b1; req_op = OP_SLL; req_lhs = 32'd1; req_rhs = 32'd33;
    #1 chk("sll_ready", 32'(req_ready), 32'd1);
    tick();
    chk("sll_valid", 32'(resp_valid), 32'd1);
    chk("sll_data", resp_data, 32'h2);
    req_op = OP_SRA; req_lhs = 32'h8000_0000; req_rhs = 32'd4;
    tick();
    chk("sra_valid", 32'(resp_valid), 32'd1);
    chk("sra_data", resp_data, 32'hF800_0000);
    req_op = OP_SLT; req_lhs = 32'hFFFF_FFFF; req_rhs = 32'd1;
    tick();
    chk("slt_valid", 32'(resp_valid), 32'd1);
    chk("slt_data", resp_data, 32'h1);
    req_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(resp_valid), 32'd0);
    run(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mulh_lat", lat, 32'd33);
    chk("mulh_data", resp_data, 32'h0);
    run(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mulhu_lat", lat, 32'd33);
    chk("mulhu_data", resp_data, 32'hFFFF_FFFE);
    run(OP_MUL, 32'hFFFF_FFFD, 32'd5);
    chk("mul_data", resp_data, 32'hFFFF_FFF1);
    run(OP_MULHSU, 32'hFFFF_FFFF, 32'd2);
    chk("mulhsu_data", resp_data, 32'hFFFF_FFFF);
`ifdef ALU_MDU_DIV_EN
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_lat", lat, 32'd33);
    chk("div_data", resp_data, 32'hFFFF_FFFD);
    run(OP_REM, 32'hFFFF_FFF9, 32'd2);
    chk("rem_data", resp_data, 32'hFFFF_FFFF);
    run(OP_DIVU, 32'd5, 32'd0);
    chk("divz_lat", lat, 32'd1);
    chk("divz_data", resp_data, 32'hFFFF_FFFF);
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_lat", lat, 32'd1);
    chk("ovf_data", resp_data, 32'h8000_0000);
    run(OP_REMU, 32'd7, 32'd3);
    chk("remu_data", resp_data, 32'd1);
    req_op = OP_DIV;
`else
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("nodiv_lat", lat, 32'd1);
    chk("nodiv_err", 32'(resp_err), 32'd1);
    chk("nodiv_data", resp_data, 32'd0);
    req_op = OP_MUL;
`endif
    req_lhs = 32'd100; req_rhs = 32'd7; req_valid = 1'b1; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (9) tick();
    kill = 1'b1; req_valid = 1'b1; req_op = OP_ADD;
    #1 chk("kill_ready", 32'(req_ready), 32'd0);
    tick();
    kill = 1'b0; req_valid = 1'b0;
    seen = 0;
    repeat (40) begin
      if (resp_valid) seen++;
      tick();
    end
    chk("kill_valid", seen, 32'd0);
    run(OP_ADD, 32'd2, 32'd3);
    chk("postkill_lat", lat, 32'd1);
    chk("postkill_data", resp_data, 32'd5);
    req_op = OP_MULHU; req_lhs = 32'd9; req_rhs = 32'd9; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_valid", 32'(resp_valid), 32'd0);
    chk("arst_data", resp_data, 32'd0);
    chk("arst_err", 32'(resp_err), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    run(OP_ADD, 32'd1, 32'd1);
    chk("postrst_data", resp_data, 32'd2);
    run(5'd25, 32'd3, 32'd4);
    chk("ill_lat", lat, 32'd1);
    chk("ill_err", 32'(resp_err), 32'd1);
    chk("ill_data", resp_data, 32'd0);
    tick();
    req_op = OP_ADD; req_lhs = 32'd10; req_rhs = 32'd20; req_valid = 1'b1; resp_ready = 1'b0;
    tick();
    req_lhs = 32'd99;
    repeat (5) begin
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_data", resp_data, 32'd30);
      chk("hold_ready", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    #1 chk("rel_ready", 32'(req_ready), 32'd1);
    tick();
    chk("rel_valid", 32'(resp_valid), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
